// File: rtl/xs3_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : xs3_serial_adder
// Brief    : Digit-serial multi-digit Excess-3 adder, LSD first, one digit per
//            clock under a start/busy/done handshake. Optional input digit
//            range check is built only when XS3_CHECK_EN is defined.
// Revision : 1.0
// ============================================================================
module xs3_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  Cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   F,
    output logic                  Cout,
    output logic                  err
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q,  state_d;
    logic [4*DIGITS-1:0]   a_q,      a_d;
    logic [4*DIGITS-1:0]   b_q,      b_d;
    logic                  carry_q,  carry_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [4*DIGITS-1:0]   result_q, result_d;
    logic [4*DIGITS-1:0]   f_q,      f_d;
    logic                  cout_q,   cout_d;

    logic                  accept;
    logic [4:0]            sum5;
    logic [3:0]            digit;
    logic [4*DIGITS+3:0]   shifted;

    // A start is honoured in DONE as well as IDLE, so back-to-back ops lose no cycle.
    assign accept  = start && (state_q != S_RUN);
    assign sum5    = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
    assign digit   = sum5[4] ? (sum5[3:0] + 4'd3) : (sum5[3:0] + 4'd13);
    assign shifted = {digit, result_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        f_d      = f_q;
        cout_d   = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    a_d      = A;
                    b_d      = B;
                    carry_d  = Cin;
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_d      = a_q >> 4;
                b_d      = b_q >> 4;
                carry_d  = sum5[4];
                cnt_d    = cnt_q + CNT_W'(1);
                result_d = shifted[4*DIGITS+3:4];
                if (cnt_q == LAST_CNT) begin
                    f_d     = shifted[4*DIGITS+3:4];
                    cout_d  = sum5[4];
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            f_q      <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            f_q      <= f_d;
            cout_q   <= cout_d;
        end
    end

`ifdef XS3_CHECK_EN
    logic err_q, err_d;
    logic bad_digit;

    // Legal XS3 digits are 0x3..0xC; anything else in either operand flags err.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((A[4*i +: 4] < 4'd3) || (A[4*i +: 4] > 4'd12) ||
                (B[4*i +: 4] < 4'd3) || (B[4*i +: 4] > 4'd12)) begin
                bad_digit = 1'b1;
            end
        end
        err_d = accept ? bad_digit : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign F    = f_q;
    assign Cout = cout_q;

endmodule
`default_nettype wire

// File: doc/xs3_serial_adder.md
Name: xs3_serial_adder

Overview:
Digit-serial, parametrised multi-digit Excess-3 (XS3) adder. Per digit, a binary 4-bit add with carry is followed by the XS3 correction: +0011 when the digit carry-out is 1, +1101 (i.e. −3 mod 16) when it is 0. The block processes one digit per clock, LSD first, under a start/busy/done handshake. It sits above the combinational single-digit XS3 adder/corrector as the multi-digit arithmetic engine for the BCD/XS3 datapath.

Parameters:
DIGITS, 4, number of XS3 digits per operand; legal range 1..16.
CNT_W, $clog2(DIGITS+1), digit counter width; localparam, not overridable.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request an operation; accepted only when busy=0.
A  input  4*DIGITS  operand A, XS3, digit i at bits [4i+3:4i].
B  input  4*DIGITS  operand B, XS3, same packing.
Cin  input  1  initial carry into digit 0.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse: F and Cout are valid.
F  output  4*DIGITS  XS3 sum, registered; holds until the next operation completes.
Cout  output  1  carry out of the most significant digit, registered with F.
err  output  1  invalid-digit flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, F=0, Cout=0, err=0, counter=0, working registers=0. Asserting reset mid-operation aborts it; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE: if start=1, capture A, B and Cin into internal shift registers, clear counter, go to RUN. busy rises the cycle after start is sampled.
- RUN: each cycle, for the current digit a,b with carry c:
  - s5 = a + b + c (5 bits); c_next = s5[4].
  - digit = c_next ? s5[3:0] + 3 : s5[3:0] + 13, both mod 16.
  - Shift digit into the result register; carry register ← c_next; counter+1.
  - After the DIGITS-th digit, load F ← result and Cout ← final carry, then go to DONE.
- DONE: busy=0, done=1 for exactly one cycle, then IDLE. A start sampled in DONE is accepted exactly as in IDLE and goes directly to RUN.
- Latency: start sampled at edge t → done high in cycle t+DIGITS+1; busy high for DIGITS cycles.
- start while busy=1: ignored, no effect on the operation in flight.
- A, B and Cin are sampled only at acceptance; later changes have no effect.
- F and Cout change only on the RUN→DONE transition; previous results stay visible during RUN.
- Digits outside the XS3 range are processed arithmetically as above; there is no saturation.
- DIGITS=1: a single RUN cycle; done high at t+2.

Optional Feature:
Macro XS3_CHECK_EN.
- Defined: at acceptance, err is registered high if any digit of A or B is outside 0x3..0xC. Otherwise err is cleared. err holds until the next accepted start; the sum is still computed.
- Not defined: err is tied to 0; no check logic is built.

Test Plan:
- DIGITS=4, A=0x4567 (1234), B=0x89AB (5678), Cin=0, pulse start → done at start+5, F=0x9C45 (6912), Cout=0, busy high for 4 cycles.
- A=0xCCCC (9999), B=0x3334 (0001), Cin=0 → F=0x3333 (0000), Cout=1.
- A=0x3333, B=0x3333, Cin=1 → F=0x3334, Cout=0. Then start in the DONE cycle with A=0x4567, B=0x89AB → second done 5 cycles later, F=0x9C45.
- Start accepted, then start re-pulsed with different operands at cycles +1 and +2 → single done at +5 with the first result. Separately, rst_n low at cycle +2 → busy=0, F=0, no done.
- XS3_CHECK_EN defined, A=0x0567 → err=1 from the cycle after acceptance, done still pulses. Next op with valid digits → err=0. Macro undefined → err always 0.
- DIGITS=1: A=0x7, B=0xB → done at start+2, F=0x5, Cout=1.
